// File: rtl/scan_mux_pkg.sv
// Shared types for the scan multiplexer: FSM state encoding, mode constants
// and the mode/enable transition rule used by the top level.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Dropping enable always wins over a simultaneous mode change; the
    // unused encoding falls back to idle.
    function automatic state_t next_state(input state_t cur, input logic enable, input logic mode);
        state_t nxt;
        case (cur)
            ST_IDLE, ST_MANUAL, ST_SCAN: begin
                if (!enable) begin
                    nxt = ST_IDLE;
                end else if (mode == MODE_SCAN) begin
                    nxt = ST_SCAN;
                end else begin
                    nxt = ST_MANUAL;
                end
            end
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/scan_mux_dwell_counter.sv
// Mod-DWELL counter with synchronous clear and step qualifier; tc flags the
// last cycle of a dwell period.
module dwell_counter
    import scan_mux_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = $clog2(DWELL + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic step,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tc = (cnt_r == LAST_CNT);

    // Dwell count register: clear has priority, otherwise wraps at LAST_CNT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (step) begin
            if (tc) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-to-1 channel multiplexer with a manual select mode and an
// auto-scan mode that presents every channel for DWELL cycles in turn.
module scan_mux_reg
    import scan_mux_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int WIDTH  = 1,
    parameter int DWELL  = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    hold,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    output logic                    scan_wrap
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(NUM_CH);

    state_t             state_r;
    state_t             ns_s;
    logic [SEL_W-1:0]   scan_ch_r;
    logic [SEL_W-1:0]   scan_ch_nxt_s;
    logic               enter_scan_s;
    logic               step_s;
    logic               advance_s;
    logic               wrap_nxt_s;
    logic               tc_s;
    logic               sel_ok_s;
    logic [WIDTH-1:0]   man_data_s;
    logic [WIDTH-1:0]   scan_data_s;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clock (clock),
        .reset (reset),
        .clear (enter_scan_s),
        .step  (step_s),
        .tc    (tc_s)
    );

    // Next state and scan-channel sequencing; outputs follow the channel the
    // scan moves to, so entry and every advance are visible one edge later.
    always_comb begin
        ns_s          = next_state(state_r, enable, mode);
        enter_scan_s  = (ns_s == ST_SCAN) && (state_r != ST_SCAN);
        step_s        = (ns_s == ST_SCAN) && (state_r == ST_SCAN) && !hold;
        advance_s     = step_s && tc_s;
        wrap_nxt_s    = advance_s && (scan_ch_r == LAST_CH);
        if (enter_scan_s) begin
            scan_ch_nxt_s = '0;
        end else if (advance_s) begin
            if (scan_ch_r == LAST_CH) begin
                scan_ch_nxt_s = '0;
            end else begin
                scan_ch_nxt_s = scan_ch_r + SEL_W'(1);
            end
        end else begin
            scan_ch_nxt_s = scan_ch_r;
        end
    end

    // Channel extraction for the manual select and the scan pointer;
    // out-of-range selects read as zero.
    always_comb begin
        sel_ok_s    = ({1'b0, sel} < CH_LIMIT);
        man_data_s  = '0;
        scan_data_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                man_data_s = in_data[k*WIDTH +: WIDTH];
            end else begin
                man_data_s = man_data_s;
            end
            if (scan_ch_nxt_s == SEL_W'(k)) begin
                scan_data_s = in_data[k*WIDTH +: WIDTH];
            end else begin
                scan_data_s = scan_data_s;
            end
        end
    end

    // State, scan pointer and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            scan_ch_r <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            state_r   <= ns_s;
            scan_ch_r <= scan_ch_nxt_s;
            case (ns_s)
                ST_MANUAL: begin
                    out_data  <= sel_ok_s ? man_data_s : '0;
                    out_ch    <= sel;
                    out_valid <= sel_ok_s;
                    scan_wrap <= 1'b0;
                end
                ST_SCAN: begin
                    out_data  <= scan_data_s;
                    out_ch    <= scan_ch_nxt_s;
                    out_valid <= 1'b1;
                    scan_wrap <= wrap_nxt_s;
                end
                default: begin
                    out_valid <= 1'b0;
                    scan_wrap <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_mux_reg.sv
// Self-checking bench: default-parameter instance against a step-count model,
// plus an 8x4-bit DWELL=1 instance for the parametrised scan.
module tb_scan_mux_reg;

    localparam int NA = 6;
    localparam int DA = 4;

    logic        clock;
    logic        reset;

    logic [5:0]  in_a;
    logic        en_a, mode_a, hold_a;
    logic [2:0]  sel_a;
    logic [0:0]  data_a;
    logic [2:0]  ch_a;
    logic        valid_a, wrap_a;

    logic [31:0] in_b;
    logic        en_b, mode_b, hold_b;
    logic [2:0]  sel_b;
    logic [3:0]  data_b;
    logic [2:0]  ch_b;
    logic        valid_b, wrap_b;

    int n_cmp;
    int n_bad;

    // reference model: scanning flag plus non-held steps since scan entry
    bit          m_scanning;
    int          m_steps;
    logic [0:0]  e_data;
    logic [2:0]  e_ch;
    logic        e_valid, e_wrap;

    scan_mux_reg dut_a (
        .clock(clock), .reset(reset), .in_data(in_a), .enable(en_a), .mode(mode_a),
        .sel(sel_a), .hold(hold_a), .out_data(data_a), .out_ch(ch_a),
        .out_valid(valid_a), .scan_wrap(wrap_a)
    );

    scan_mux_reg #(.NUM_CH(8), .WIDTH(4), .DWELL(1)) dut_b (
        .clock(clock), .reset(reset), .in_data(in_b), .enable(en_b), .mode(mode_b),
        .sel(sel_b), .hold(hold_b), .out_data(data_b), .out_ch(ch_b),
        .out_valid(valid_b), .scan_wrap(wrap_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_scanning = 1'b0;
        m_steps    = 0;
        e_data     = 1'b0;
        e_ch       = 3'd0;
        e_valid    = 1'b0;
        e_wrap     = 1'b0;
    endtask

    task automatic drive_a(input logic en, input logic md, input logic [2:0] s,
                           input logic h, input logic [5:0] d);
        int c;
        en_a = en; mode_a = md; sel_a = s; hold_a = h; in_a = d;
        @(posedge clock);
        e_wrap = 1'b0;
        if (!en) begin
            e_valid    = 1'b0;
            m_scanning = 1'b0;
        end else if (!md) begin
            m_scanning = 1'b0;
            e_ch       = s;
            if (int'(s) < NA) begin
                e_data  = d[s];
                e_valid = 1'b1;
            end else begin
                e_data  = 1'b0;
                e_valid = 1'b0;
            end
        end else begin
            if (!m_scanning) begin
                m_steps = 0;
            end else if (!h) begin
                m_steps++;
                e_wrap = (m_steps % (NA * DA) == 0);
            end
            m_scanning = 1'b1;
            c       = (m_steps / DA) % NA;
            e_ch    = 3'(c);
            e_data  = d[c];
            e_valid = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({data_a, ch_a, valid_a, wrap_a} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_a: got d=%0h ch=%0d v=%0b w=%0b want all 0", data_a, ch_a, valid_a, wrap_a);
        end
        n_cmp++;
        if ({data_b, ch_b, valid_b, wrap_b} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_b: got d=%0h ch=%0d v=%0b w=%0b want all 0", data_b, ch_b, valid_b, wrap_b);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            drive_a(1'b1, 1'b1, 3'd0, 1'b0, 6'($urandom));
            if (e_ch == 3'd3) break;
        end
        n_cmp++;
        if (ch_a !== 3'd3) begin
            n_bad++;
            $display("FAIL reset_prescan: got ch=%0d want 3", ch_a);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({data_a, ch_a, valid_a, wrap_a} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_midscan: got d=%0h ch=%0d v=%0b w=%0b want all 0", data_a, ch_a, valid_a, wrap_a);
        end
        @(negedge clock);
        reset = 1'b0;
        drive_a(1'b1, 1'b1, 3'd0, 1'b0, 6'h3f);
        n_cmp++;
        if ({data_a, ch_a, valid_a, wrap_a} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_release: got d=%0h ch=%0d v=%0b w=%0b want d=1 ch=0 v=1 w=0", data_a, ch_a, valid_a, wrap_a);
        end
    endtask

    task automatic test_manual();
        drive_a(1'b1, 1'b0, 3'd1, 1'b0, 6'b101010);
        n_cmp++;
        if ({data_a, ch_a, valid_a, wrap_a} !== {1'b1, 3'd1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL manual_sel1: got d=%0h ch=%0d v=%0b w=%0b want d=1 ch=1 v=1 w=0", data_a, ch_a, valid_a, wrap_a);
        end
        drive_a(1'b1, 1'b0, 3'd6, 1'b0, 6'b101010);
        n_cmp++;
        if ({data_a, ch_a, valid_a, wrap_a} !== {1'b0, 3'd6, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL manual_sel6: got d=%0h ch=%0d v=%0b w=%0b want d=0 ch=6 v=0 w=0", data_a, ch_a, valid_a, wrap_a);
        end
        for (int i = 0; i < 16; i++) begin
            drive_a(1'b1, 1'b0, 3'(i % 8), 1'b0, 6'($urandom));
            n_cmp++;
            if ({data_a, ch_a, valid_a, wrap_a} !== {e_data, e_ch, e_valid, e_wrap}) begin
                n_bad++;
                $display("FAIL manual_rand %0d: got d=%0h ch=%0d v=%0b w=%0b want d=%0h ch=%0d v=%0b w=%0b",
                         i, data_a, ch_a, valid_a, wrap_a, e_data, e_ch, e_valid, e_wrap);
            end
        end
    endtask

    task automatic test_scan_sequence();
        int wraps;
        wraps = 0;
        drive_a(1'b0, 1'b0, 3'd0, 1'b0, 6'($urandom));
        n_cmp++;
        if ({data_a, ch_a, valid_a, wrap_a} !== {e_data, e_ch, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL idle_hold: got d=%0h ch=%0d v=%0b want d=%0h ch=%0d v=0", data_a, ch_a, valid_a, e_data, e_ch);
        end
        for (int i = 0; i <= 48; i++) begin
            drive_a(1'b1, 1'b1, 3'd0, 1'b0, 6'($urandom));
            if (wrap_a === 1'b1) wraps++;
            n_cmp++;
            if ({data_a, ch_a, valid_a, wrap_a} !== {e_data, e_ch, e_valid, e_wrap}) begin
                n_bad++;
                $display("FAIL scan_seq %0d: got d=%0h ch=%0d v=%0b w=%0b want d=%0h ch=%0d v=%0b w=%0b",
                         i, data_a, ch_a, valid_a, wrap_a, e_data, e_ch, e_valid, e_wrap);
            end
            if (i < 8) begin
                n_cmp++;
                if (ch_a !== 3'(i / 4)) begin
                    n_bad++;
                    $display("FAIL scan_first8 %0d: got ch=%0d want %0d", i, ch_a, i / 4);
                end
            end
        end
        n_cmp++;
        if (wraps !== 2) begin
            n_bad++;
            $display("FAIL scan_wrap_count: got %0d want 2", wraps);
        end
    endtask

    task automatic test_hold();
        int run_len;
        run_len = 0;
        drive_a(1'b0, 1'b0, 3'd0, 1'b0, 6'($urandom));
        for (int i = 0; i < 40; i++) begin
            drive_a(1'b1, 1'b1, 3'd0, 1'b0, 6'($urandom));
            if (e_ch == 3'd2) break;
        end
        drive_a(1'b1, 1'b1, 3'd0, 1'b0, 6'($urandom));
        for (int i = 0; i < 10; i++) begin
            drive_a(1'b1, 1'b1, 3'd0, 1'b1, 6'($urandom));
            n_cmp++;
            if ({data_a, ch_a, valid_a, wrap_a} !== {e_data, 3'd2, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL hold %0d: got d=%0h ch=%0d v=%0b w=%0b want d=%0h ch=2 v=1 w=0",
                         i, data_a, ch_a, valid_a, wrap_a, e_data);
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive_a(1'b1, 1'b1, 3'd0, 1'b0, 6'($urandom));
            n_cmp++;
            if ({data_a, ch_a, valid_a, wrap_a} !== {e_data, e_ch, e_valid, e_wrap}) begin
                n_bad++;
                $display("FAIL hold_release %0d: got d=%0h ch=%0d v=%0b w=%0b want d=%0h ch=%0d v=%0b w=%0b",
                         i, data_a, ch_a, valid_a, wrap_a, e_data, e_ch, e_valid, e_wrap);
            end
            if (ch_a !== 3'd2) break;
            run_len++;
        end
        n_cmp++;
        if (run_len !== 2 || ch_a !== 3'd3) begin
            n_bad++;
            $display("FAIL hold_remaining: got %0d more cycles then ch=%0d want 2 then ch=3", run_len, ch_a);
        end
    endtask

    task automatic test_mode_switch();
        drive_a(1'b1, 1'b0, 3'd0, 1'b0, 6'($urandom));
        for (int i = 0; i < 40; i++) begin
            drive_a(1'b1, 1'b1, 3'd0, 1'b0, 6'($urandom));
            if (e_ch == 3'd4) break;
        end
        drive_a(1'b1, 1'b0, 3'd1, 1'b0, 6'b000010);
        n_cmp++;
        if ({data_a, ch_a, valid_a, wrap_a} !== {1'b1, 3'd1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL mode_to_manual: got d=%0h ch=%0d v=%0b w=%0b want d=1 ch=1 v=1 w=0", data_a, ch_a, valid_a, wrap_a);
        end
        drive_a(1'b1, 1'b1, 3'd1, 1'b0, 6'b000001);
        n_cmp++;
        if ({data_a, ch_a, valid_a, wrap_a} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL mode_to_scan: got d=%0h ch=%0d v=%0b w=%0b want d=1 ch=0 v=1 w=0", data_a, ch_a, valid_a, wrap_a);
        end
    endtask

    task automatic test_random();
        logic md;
        md = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(15, 0) == 0) md = ~md;
            drive_a(($urandom_range(7, 0) != 0), md, 3'($urandom), ($urandom_range(3, 0) == 0), 6'($urandom));
            n_cmp++;
            if ({data_a, ch_a, valid_a, wrap_a} !== {e_data, e_ch, e_valid, e_wrap}) begin
                n_bad++;
                $display("FAIL random %0d: got d=%0h ch=%0d v=%0b w=%0b want d=%0h ch=%0d v=%0b w=%0b",
                         i, data_a, ch_a, valid_a, wrap_a, e_data, e_ch, e_valid, e_wrap);
            end
        end
    endtask

    task automatic test_param_dwell1();
        for (int k = 0; k < 8; k++) in_b[k*4 +: 4] = 4'(k + 1);
        en_b = 1'b1; mode_b = 1'b1; hold_b = 1'b0; sel_b = 3'd0;
        for (int i = 0; i <= 8; i++) begin
            @(posedge clock);
            #1;
            n_cmp++;
            if ({data_b, ch_b, valid_b, wrap_b} !== {4'((i % 8) + 1), 3'(i % 8), 1'b1, (i == 8)}) begin
                n_bad++;
                $display("FAIL param_scan %0d: got d=%0h ch=%0d v=%0b w=%0b want d=%0h ch=%0d v=1 w=%0b",
                         i, data_b, ch_b, valid_b, wrap_b, (i % 8) + 1, i % 8, (i == 8));
            end
        end
        en_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            in_b = $urandom;
            n_cmp++;
            if ({data_b, ch_b, valid_b, wrap_b} !== {4'd1, 3'd0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL param_disable %0d: got d=%0h ch=%0d v=%0b w=%0b want d=1 ch=0 v=0 w=0",
                         i, data_b, ch_b, valid_b, wrap_b);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        in_a = 6'd0; en_a = 1'b0; mode_a = 1'b0; hold_a = 1'b0; sel_a = 3'd0;
        in_b = 32'd0; en_b = 1'b0; mode_b = 1'b0; hold_b = 1'b0; sel_b = 3'd0;
        model_reset();
        #3;
        test_reset();
        test_manual();
        test_scan_sequence();
        test_hold();
        test_mode_switch();
        test_random();
        test_param_dwell1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
